// File: rtl/instruction_refill_unit.sv
// Instruction cache refill engine: fetches one cacheline beat-by-beat
// from backing memory and returns it to the cache as a single response.
module instruction_refill_unit #(
    parameter int unsigned PcWidth          = 32,
    parameter int unsigned EncInstWidth     = 32,
    parameter int unsigned CachelineIdxBits = 1
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic                                            ic_req_i,
    output logic                                            ic_ready_o,
    input  logic [PcWidth-CachelineIdxBits-1:0]             ic_addr_i,
    output logic                                            ic_valid_o,
    output logic [(EncInstWidth << CachelineIdxBits)-1:0]   ic_data_o,
    output logic                                            imem_req_o,
    input  logic                                            imem_gnt_i,
    output logic [PcWidth-1:0]                              imem_addr_o,
    input  logic                                            imem_rvalid_i,
    input  logic [EncInstWidth-1:0]                         imem_rdata_i
);

    localparam int unsigned N     = 1 << CachelineIdxBits;
    localparam int unsigned CntW  = CachelineIdxBits + 1;
    localparam int unsigned LineW = PcWidth - CachelineIdxBits;
    localparam logic [CntW-1:0] NCnt    = CntW'(N);
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        RESPOND = 2'd2
    } state_e;

    state_e                           state_q, state_d;
    logic [CntW-1:0]                  issue_cnt_q, issue_cnt_d;
    logic [CntW-1:0]                  recv_cnt_q, recv_cnt_d;
    logic [LineW-1:0]                 line_q, line_d;
    logic [N-1:0][EncInstWidth-1:0]   data_q, data_d;
    logic                             issue_fire;
    logic                             recv_fire;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        line_d      = line_q;
        data_d      = data_q;
        ic_ready_o  = (state_q == IDLE);
        ic_valid_o  = (state_q == RESPOND);
        imem_req_o  = (state_q == FETCH) && (issue_cnt_q < NCnt);
        issue_fire  = imem_req_o && imem_gnt_i;
        // Data beats are only taken while a line is in flight.
        recv_fire   = (state_q == FETCH) && imem_rvalid_i
                      && (recv_cnt_q < NCnt);

        unique case (state_q)
            IDLE: begin
                if (ic_req_i) begin
                    line_d      = ic_addr_i;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (issue_fire) begin
                    issue_cnt_d = issue_cnt_q + CntW'(1);
                end
                if (recv_fire) begin
                    for (int i = 0; i < N; i++) begin
                        if (recv_cnt_q == CntW'(i)) begin
                            data_d[i] = imem_rdata_i;
                        end
                    end
                    recv_cnt_d = recv_cnt_q + CntW'(1);
                    if (recv_cnt_q == LastCnt) begin
                        state_d = RESPOND;
                    end
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            line_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            line_q      <= line_d;
            data_q      <= data_d;
        end
    end

    if (CachelineIdxBits == 0) begin : g_addr_line
        assign imem_addr_o = line_q;
    end else begin : g_addr_beat
        assign imem_addr_o = {line_q, issue_cnt_q[CachelineIdxBits-1:0]};
    end

    assign ic_data_o = data_q;

`ifndef SYNTHESIS
    a_rvalid_unexpected : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_q == FETCH && imem_rvalid_i && !issue_fire)
        |-> (recv_cnt_q != issue_cnt_q)
    );

    a_addr_stable : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (ic_req_i && !ic_ready_o && $past(ic_req_i && !ic_ready_o))
        |-> $stable(ic_addr_i)
    );

    a_valid_pulse : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        ic_valid_o |=> !ic_valid_o
    );
`endif

endmodule

// File: tb/tb_instruction_refill_unit.sv
// Directed bench: a 2-instruction line build and a 1-instruction line
// build, each driven cycle by cycle against hand-computed results.
module tb_instruction_refill_unit;

    logic        clk;
    int          n_checks;
    int          n_fail;
    int          cyc;

    // 2-instruction line instance
    logic        a_rst_n, a_req, a_ready, a_valid;
    logic [30:0] a_addr;
    logic [63:0] a_data;
    logic        a_imem_req, a_gnt, a_rvalid;
    logic [31:0] a_imem_addr, a_rdata;

    // 1-instruction line instance
    logic        b_rst_n, b_req, b_ready, b_valid;
    logic [31:0] b_addr;
    logic [31:0] b_data;
    logic        b_imem_req, b_gnt, b_rvalid;
    logic [31:0] b_imem_addr, b_rdata;

    // memory model state
    bit          mem_en;
    bit          mem_zl;
    int          stall_left;
    bit          pend_v;
    logic [31:0] pend_d;
    logic [31:0] a_req_log[$];
    logic [63:0] a_resp[$];
    int          a_vcyc[$];

    instruction_refill_unit #(
        .PcWidth(32), .EncInstWidth(32), .CachelineIdxBits(1)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(a_rst_n),
        .ic_req_i(a_req), .ic_ready_o(a_ready), .ic_addr_i(a_addr),
        .ic_valid_o(a_valid), .ic_data_o(a_data),
        .imem_req_o(a_imem_req), .imem_gnt_i(a_gnt),
        .imem_addr_o(a_imem_addr), .imem_rvalid_i(a_rvalid),
        .imem_rdata_i(a_rdata)
    );

    instruction_refill_unit #(
        .PcWidth(32), .EncInstWidth(32), .CachelineIdxBits(0)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(b_rst_n),
        .ic_req_i(b_req), .ic_ready_o(b_ready), .ic_addr_i(b_addr),
        .ic_valid_o(b_valid), .ic_data_o(b_data),
        .imem_req_o(b_imem_req), .imem_gnt_i(b_gnt),
        .imem_addr_o(b_imem_addr), .imem_rvalid_i(b_rvalid),
        .imem_rdata_i(b_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(logic [31:0] addr);
        case (addr)
            32'h2468: return 32'h0000_000A;
            32'h2469: return 32'h0000_000B;
            32'h0020: return 32'h0000_0011;
            32'h0021: return 32'h0000_0022;
            32'h0002: return 32'h0000_0031;
            32'h0003: return 32'h0000_0032;
            32'h0004: return 32'h0000_0041;
            32'h0005: return 32'h0000_0042;
            default:  return 32'hBAD0_0000;
        endcase
    endfunction

    // One clock of instance A: sample response, then drive the memory.
    task automatic a_step();
        @(posedge clk);
        #1;
        cyc++;
        if (a_valid) begin
            a_resp.push_back(a_data);
            a_vcyc.push_back(cyc);
        end
        a_gnt    = 1'b0;
        a_rvalid = 1'b0;
        if (mem_en && !mem_zl && pend_v) begin
            a_rvalid = 1'b1;
            a_rdata  = pend_d;
        end
        pend_v = 1'b0;
        if (mem_en && a_imem_req) begin
            a_req_log.push_back(a_imem_addr);
            if (stall_left > 0) begin
                stall_left--;
            end else begin
                a_gnt = 1'b1;
                if (mem_zl) begin
                    a_rvalid = 1'b1;
                    a_rdata  = mem_word(a_imem_addr);
                end else begin
                    pend_v = 1'b1;
                    pend_d = mem_word(a_imem_addr);
                end
            end
        end
    endtask

    task automatic a_clear();
        a_req_log.delete();
        a_resp.delete();
        a_vcyc.delete();
    endtask

    task automatic a_request(logic [30:0] addr, output int hcyc);
        a_req  = 1'b1;
        a_addr = addr;
        for (int k = 0; k < 20; k++) begin
            if (a_ready) break;
            a_step();
        end
        chk("req_ready_timeout", 64'(a_ready), 64'd1);
        hcyc = cyc;
        a_step();
        a_req = 1'b0;
    endtask

    task automatic a_wait_resp(int n);
        for (int k = 0; k < 60; k++) begin
            if (a_resp.size() >= n) break;
            a_step();
        end
        chk("resp_timeout", 64'(a_resp.size()), 64'(n));
    endtask

    task automatic b_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int h;
        int hs;
        int hc[2];
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        a_rst_n = 1'b0; a_req = 1'b0; a_addr = '0;
        a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = '0;
        b_rst_n = 1'b0; b_req = 1'b0; b_addr = '0;
        b_gnt = 1'b0; b_rvalid = 1'b0; b_rdata = '0;
        mem_en = 1'b0; mem_zl = 1'b0; stall_left = 0;
        pend_v = 1'b0; pend_d = '0;

        // reset state
        a_step();
        a_step();
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        a_step();
        chk("rst_ready", 64'(a_ready), 64'd1);
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_imem_req", 64'(a_imem_req), 64'd0);
        chk("rst_imem_addr", 64'(a_imem_addr), 64'd0);
        chk("rst_data", a_data, 64'd0);
        chk("rst_b_ready", 64'(b_ready), 64'd1);
        chk("rst_b_data", 64'(b_data), 64'd0);

        // basic refill, rvalid one cycle after grant
        mem_en = 1'b1;
        a_clear();
        a_request(31'h1234, h);
        a_wait_resp(1);
        for (int k = 0; k < 3; k++) a_step();
        chk("basic_nresp", 64'(a_resp.size()), 64'd1);
        chk("basic_data", a_resp[0], 64'h0000_000B_0000_000A);
        chk("basic_nreq", 64'(a_req_log.size()), 64'd2);
        chk("basic_addr0", 64'(a_req_log[0]), 64'h2468);
        chk("basic_addr1", 64'(a_req_log[1]), 64'h2469);
        chk("basic_data_idle", a_data, 64'h0000_000B_0000_000A);

        // grant stalled three cycles on beat 0
        a_clear();
        stall_left = 3;
        a_request(31'h1234, h);
        a_wait_resp(1);
        chk("stall_nreq", 64'(a_req_log.size()), 64'd5);
        for (int k = 0; k < 4; k++) begin
            chk("stall_addr_hold", 64'(a_req_log[k]), 64'h2468);
        end
        chk("stall_addr1", 64'(a_req_log[4]), 64'h2469);
        chk("stall_data", a_resp[0], 64'h0000_000B_0000_000A);

        // zero-latency memory: response three cycles after handshake
        a_clear();
        mem_zl = 1'b1;
        a_request(31'h10, h);
        for (int k = 1; k <= 3; k++) begin
            chk("zl_cycle", 64'(cyc - h), 64'(k));
            chk("zl_ready_low", 64'(a_ready), 64'd0);
            chk("zl_valid", 64'(a_valid), (k == 3) ? 64'd1 : 64'd0);
            a_step();
        end
        chk("zl_data", a_data, 64'h0000_0022_0000_0011);
        chk("zl_ready_back", 64'(a_ready), 64'd1);
        chk("zl_valid_end", 64'(a_valid), 64'd0);
        chk("zl_nresp", 64'(a_resp.size()), 64'd1);
        mem_zl = 1'b0;

        // reset in the middle of a fetch
        a_rst_n = 1'b0;
        a_step();
        a_rst_n = 1'b1;
        a_step();
        a_clear();
        mem_en = 1'b0;
        a_request(31'h1234, h);
        chk("mid_imem_req", 64'(a_imem_req), 64'd1);
        chk("mid_imem_addr", 64'(a_imem_addr), 64'h2468);
        a_gnt = 1'b1;
        a_step();
        a_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(a_valid), 64'd0);
        chk("mid_rst_data", a_data, 64'd0);
        a_step();
        a_rst_n  = 1'b1;
        a_rvalid = 1'b1;
        a_rdata  = 32'h0000_000A;
        a_step();
        chk("mid_stale_data", a_data, 64'd0);
        chk("mid_stale_ready", 64'(a_ready), 64'd1);
        chk("mid_stale_req", 64'(a_imem_req), 64'd0);
        for (int k = 0; k < 5; k++) a_step();
        chk("mid_no_resp", 64'(a_resp.size()), 64'd0);
        chk("mid_data_hold", a_data, 64'd0);
        mem_en = 1'b1;
        a_request(31'h10, h);
        a_wait_resp(1);
        chk("mid_next_data", a_resp[0], 64'h0000_0022_0000_0011);

        // back-to-back requests with ic_req_i held high
        a_step();
        a_clear();
        hs = 0;
        hc[0] = 0;
        hc[1] = 0;
        a_req  = 1'b1;
        a_addr = 31'h1;
        for (int k = 0; k < 80; k++) begin
            if (a_ready && a_req && hs < 2) begin
                hc[hs] = cyc;
                hs++;
            end
            a_step();
            if (hs == 1) a_addr = 31'h2;
            if (hs == 2) a_req = 1'b0;
            if (a_resp.size() >= 2) break;
        end
        a_req = 1'b0;
        chk("b2b_nhs", 64'(hs), 64'd2);
        chk("b2b_nresp", 64'(a_resp.size()), 64'd2);
        chk("b2b_accept_cyc", 64'(hc[1]), 64'(a_vcyc[0] + 1));
        chk("b2b_data0", a_resp[0], 64'h0000_0032_0000_0031);
        chk("b2b_data1", a_resp[1], 64'h0000_0042_0000_0041);

        // single-instruction line
        b_req  = 1'b1;
        b_addr = 32'h40;
        b_step();
        b_req = 1'b0;
        chk("n1_imem_req", 64'(b_imem_req), 64'd1);
        chk("n1_imem_addr", 64'(b_imem_addr), 64'h40);
        chk("n1_ready_low", 64'(b_ready), 64'd0);
        b_gnt    = 1'b1;
        b_rvalid = 1'b1;
        b_rdata  = 32'h0000_DEAD;
        b_step();
        b_gnt    = 1'b0;
        b_rvalid = 1'b0;
        chk("n1_no_second_req", 64'(b_imem_req), 64'd0);
        chk("n1_valid", 64'(b_valid), 64'd1);
        chk("n1_data", 64'(b_data), 64'h0000_DEAD);
        b_step();
        chk("n1_valid_end", 64'(b_valid), 64'd0);
        chk("n1_ready_back", 64'(b_ready), 64'd1);
        chk("n1_data_hold", 64'(b_data), 64'h0000_DEAD);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
